// File: rtl/dsd_pkg.sv
// Shared definitions for the DSD lab datapath blocks: operation codes
// for the universal shift register and a helper to size its shift counter.
package dsd_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    // Bits needed to count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// Saturating shift counter with a one-cycle DONE pulse on the edge where
// the count first reaches WIDTH (i.e. a full word has been shifted).
module shift_cnt
    import dsd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          cnt_clr,
    input  logic                          cnt_inc,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_reg;
    logic          done_reg;

    // Count shift ops since the last load/clear; pulse done when the count
    // steps from WIDTH-1 to WIDTH, never again while saturated.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (!en) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc && (cnt_reg != CNT_MAX)) begin
                cnt_reg  <= cnt_reg + 1'b1;
                done_reg <= (cnt_reg == CNT_PRE);
            end
        end
    end

    assign cnt  = cnt_reg;
    assign done = done_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, load, logical/arithmetic
// shifts, rotates and clear, with serial outputs at both ends and a
// full-word shift counter for serializer/deserializer use.
module univ_shift_reg
    import dsd_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          EN,
    input  logic [2:0]                    MODE,
    input  logic [WIDTH-1:0]              D,
    input  logic                          SIL,
    input  logic                          SIR,
    output logic [WIDTH-1:0]              Q,
    output logic [WIDTH-1:0]              Qn,
    output logic                          SO_L,
    output logic                          SO_R,
    output logic [cnt_width(WIDTH)-1:0]   CNT,
    output logic                          DONE
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             cnt_clr;
    logic             cnt_inc;

    // Next-state mux; each serial input is only consulted by the one mode
    // that consumes it, so an undriven SIL/SIR cannot leak into Q.
    always_comb begin
        q_next = q_reg;
        case (MODE)
            MODE_HOLD:  q_next = q_reg;
            MODE_LOAD:  q_next = D;
            MODE_SHL:   q_next = {q_reg[WIDTH-2:0], SIL};
            MODE_SHR:   q_next = {SIR, q_reg[WIDTH-1:1]};
            MODE_ROL:   q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            MODE_ROR:   q_next = {q_reg[0], q_reg[WIDTH-1:1]};
            MODE_ASR:   q_next = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
            MODE_CLEAR: q_next = '0;
            default:    q_next = q_reg;
        endcase
    end

    // Register bank: CLR wins over everything, EN low freezes the word.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_reg <= RESET_VAL;
        end else if (EN) begin
            q_reg <= q_next;
        end
    end

    // Counter control: load/clear re-arm, any shift or rotate advances.
    always_comb begin
        cnt_clr = (MODE == MODE_LOAD) || (MODE == MODE_CLEAR);
        cnt_inc = (MODE == MODE_SHL) || (MODE == MODE_SHR) ||
                  (MODE == MODE_ROL) || (MODE == MODE_ROR) ||
                  (MODE == MODE_ASR);
    end

    shift_cnt #(
        .WIDTH (WIDTH)
    ) u_shift_cnt (
        .clk     (CLK),
        .clr     (CLR),
        .en      (EN),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .cnt     (CNT),
        .done    (DONE)
    );

    // Complementary outputs, bit by bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qn
            assign Qn[gi] = ~q_reg[gi];
        end
    endgenerate

    assign Q    = q_reg;
    assign SO_L = q_reg[WIDTH-1];
    assign SO_R = q_reg[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4, RESET_VAL=1010.
module tb_univ_shift_reg;
    import dsd_pkg::*;

    localparam int W = 4;
    localparam int CW = cnt_width(W);

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sil;
    logic          sir;
    logic [W-1:0]  q;
    logic [W-1:0]  qn;
    logic          so_l;
    logic          so_r;
    logic [CW-1:0] cnt;
    logic          done;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (4'b1010)
    ) dut (
        .CLK  (clk),
        .CLR  (clr),
        .EN   (en),
        .MODE (mode),
        .D    (d),
        .SIL  (sil),
        .SIR  (sir),
        .Q    (q),
        .Qn   (qn),
        .SO_L (so_l),
        .SO_R (so_r),
        .CNT  (cnt),
        .DONE (done)
    );

    always #5 clk = ~clk;

    // Apply one operation across a rising edge and print the monitor line.
    task automatic tick(input logic c, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dv, input logic sl, input logic sr);
        clr = c; en = e; mode = m; d = dv; sil = sl; sir = sr;
        @(posedge clk);
        #1;
        $display("t=%0t CLR=%b MODE=%03b Q=%b Qn=%b CNT=%0d DONE=%b",
                 $time, clr, mode, q, qn, cnt, done);
    endtask

    task automatic test_reset();
        tick(1, 0, MODE_SHL, 4'b0000, 1'bx, 1'bx);
        tick(1, 1, MODE_LOAD, 4'b1111, 0, 0);
        checks++; if (q !== 4'b1010) begin errors++; $display("FAIL reset_q got=%b exp=1010", q); end
        checks++; if (qn !== 4'b0101) begin errors++; $display("FAIL reset_qn got=%b exp=0101", qn); end
        checks++; if (so_l !== 1'b1 || so_r !== 1'b0) begin errors++; $display("FAIL reset_so got=%b%b exp=10", so_l, so_r); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        tick(0, 1, MODE_HOLD, 4'b0000, 0, 0);
        checks++; if (q !== 4'b1010) begin errors++; $display("FAIL hold_q got=%b exp=1010", q); end
    endtask

    task automatic test_shl_done();
        logic [W-1:0] exp_q [0:3];
        exp_q = '{4'b1101, 4'b1011, 4'b0111, 4'b1111};
        tick(0, 1, MODE_LOAD, 4'b0110, 0, 0);
        checks++; if (q !== 4'b0110 || cnt !== 3'd0) begin errors++; $display("FAIL load got q=%b cnt=%0d exp q=0110 cnt=0", q, cnt); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, MODE_SHL, 4'b0000, 1, 1'bx);
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shl_q[%0d] got=%b exp=%b", i, q, exp_q[i]); end
            checks++; if (cnt !== CW'(i + 1)) begin errors++; $display("FAIL shl_cnt[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL shl_done[%0d] got=%b exp=%b", i, done, i == 3); end
        end
        tick(0, 1, MODE_SHL, 4'b0000, 1, 1'bx);
        checks++; if (q !== 4'b1111 || cnt !== 3'd4 || done !== 1'b0) begin
            errors++; $display("FAIL shl_sat got q=%b cnt=%0d done=%b exp q=1111 cnt=4 done=0", q, cnt, done);
        end
    endtask

    task automatic test_right_shifts();
        tick(0, 1, MODE_LOAD, 4'b1001, 0, 0);
        checks++; if (so_r !== 1'b1) begin errors++; $display("FAIL load_sor got=%b exp=1", so_r); end
        tick(0, 1, MODE_ASR, 4'b0000, 1'bx, 0);
        checks++; if (q !== 4'b1100 || so_r !== 1'b0) begin errors++; $display("FAIL asr1 got q=%b so_r=%b exp q=1100 so_r=0", q, so_r); end
        tick(0, 1, MODE_ASR, 4'b0000, 1'bx, 0);
        checks++; if (q !== 4'b1110 || so_r !== 1'b0) begin errors++; $display("FAIL asr2 got q=%b so_r=%b exp q=1110 so_r=0", q, so_r); end
        tick(0, 1, MODE_LOAD, 4'b1001, 0, 0);
        tick(0, 1, MODE_SHR, 4'b0000, 1'bx, 0);
        checks++; if (q !== 4'b0100 || so_r !== 1'b0 || so_l !== 1'b0) begin
            errors++; $display("FAIL shr got q=%b so_l=%b so_r=%b exp q=0100 so_l=0 so_r=0", q, so_l, so_r);
        end
    endtask

    task automatic test_rotates();
        logic [W-1:0] exp_q [0:3];
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tick(0, 1, MODE_LOAD, 4'b1000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, MODE_ROL, 4'b0000, 1'bx, 1'bx);
            checks++; if (q !== exp_q[i] || done !== (i == 3)) begin
                errors++; $display("FAIL rol[%0d] got q=%b done=%b exp q=%b done=%b", i, q, done, exp_q[i], i == 3);
            end
        end
        tick(0, 1, MODE_ROR, 4'b0000, 1'bx, 1'bx);
        checks++; if (q !== 4'b0100 || cnt !== 3'd4 || done !== 1'b0) begin
            errors++; $display("FAIL ror got q=%b cnt=%0d done=%b exp q=0100 cnt=4 done=0", q, cnt, done);
        end
    endtask

    task automatic test_enable_clear();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, MODE_SHL, 4'b0000, 1, 1);
            checks++; if (q !== 4'b0100 || cnt !== 3'd4 || done !== 1'b0) begin
                errors++; $display("FAIL en_low[%0d] got q=%b cnt=%0d done=%b exp q=0100 cnt=4 done=0", i, q, cnt, done);
            end
        end
        tick(0, 1, MODE_CLEAR, 4'b1111, 1, 1);
        checks++; if (q !== 4'b0000 || qn !== 4'b1111 || cnt !== 3'd0) begin
            errors++; $display("FAIL clear got q=%b qn=%b cnt=%0d exp q=0000 qn=1111 cnt=0", q, qn, cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) tick(0, 1, MODE_SHL, 4'b0000, 0, 1'bx);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        tick(0, 1, MODE_LOAD, 4'b0011, 0, 0);
        checks++; if (q !== 4'b0011 || cnt !== 3'd0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_load got q=%b cnt=%0d done=%b exp q=0011 cnt=0 done=0", q, cnt, done);
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 1, MODE_SHL, 4'b0000, 1, 1'bx);
        tick(0, 1, MODE_SHL, 4'b0000, 1, 1'bx);
        checks++; if (q !== 4'b1111 || cnt !== 3'd2) begin errors++; $display("FAIL mid_pre got q=%b cnt=%0d exp q=1111 cnt=2", q, cnt); end
        tick(1, 1, MODE_LOAD, 4'b1111, 0, 0);
        checks++; if (q !== 4'b1010 || cnt !== 3'd0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_clr got q=%b cnt=%0d done=%b exp q=1010 cnt=0 done=0", q, cnt, done);
        end
        tick(0, 1, MODE_HOLD, 4'b0000, 0, 0);
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; sil = 1'b0; sir = 1'b0;
        test_reset();
        test_shl_done();
        test_right_shifts();
        test_rotates();
        test_enable_clear();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the single D flip-flop cell: a WIDTH-bit register bank with complementary outputs.
- Supports hold, parallel load, logical and arithmetic shifts, rotates and clear, with serial in/out on both ends.
- A shift counter flags when a full word has been shifted, so the block can act as the serializer/deserializer stage in the DSD lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 32.
- RESET_VAL, 0, value Q takes on CLR; WIDTH bits wide.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  synchronous, active-high reset.
- EN  input  1  operation enable; when low, the register, counter and DONE all hold/clear as below.
- MODE  input  3  operation select.
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial input entering at the LSB on a shift left.
- SIR  input  1  serial input entering at the MSB on a shift right.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q (combinational).
- SO_L  output  1  Q[WIDTH-1] (combinational).
- SO_R  output  1  Q[0] (combinational).
- CNT  output  $clog2(WIDTH+1)  number of shift/rotate ops since the last load, clear or reset; saturates at WIDTH.
- DONE  output  1  registered one-cycle pulse on the edge where CNT becomes WIDTH.

Behaviour:
- All state updates on the rising edge of CLK.
- CLR high has top priority, regardless of EN or MODE: Q<=RESET_VAL, CNT<=0, DONE<=0.
- Reset outputs: Q=RESET_VAL, Qn=~RESET_VAL, SO_L/SO_R = the corresponding RESET_VAL bits, CNT=0, DONE=0.
- EN low: Q and CNT hold; DONE<=0.
- MODE encoding when EN=1, CLR=0:
  - 000 HOLD: Q holds.
  - 001 LOAD: Q<=D.
  - 010 SHL: Q<={Q[WIDTH-2:0],SIL}.
  - 011 SHR: Q<={SIR,Q[WIDTH-1:1]}.
  - 100 ROL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 ROR: Q<={Q[0],Q[WIDTH-1:1]}.
  - 110 ASR: Q<={Q[WIDTH-1],Q[WIDTH-1:1]}; SIR is ignored.
  - 111 CLEAR: Q<=0 (not RESET_VAL).
- Latency: Q reflects the operation one cycle after the edge on which it is sampled. Qn, SO_L and SO_R follow Q combinationally, with no added latency.
- Counter, on each edge with EN=1:
  - LOAD and CLEAR set CNT<=0.
  - SHL, SHR, ROL, ROR and ASR set CNT<=min(CNT+1,WIDTH).
  - HOLD leaves CNT unchanged.
- DONE<=1 only on the edge where CNT goes from WIDTH-1 to WIDTH; otherwise DONE<=0.
  - While saturated at WIDTH, further shifts do not re-pulse DONE.
  - A LOAD after saturation re-arms the counter.
- Simultaneous events: CLR overrides all modes. A LOAD issued in the cycle after DONE is legal and clears CNT normally.
- Reset mid-shift: the partial word is discarded and CNT returns to 0 on that edge.
- No X propagation is allowed from the SIL/SIR input that the selected mode does not use.

Decomposition:
- Shared package dsd_pkg holds:
  - MODE localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLEAR.
  - A function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One natural sub-module: shift_cnt, the saturating counter plus DONE pulse generator, parametrised by WIDTH.
- The next-Q mux stays in the top level.
- The self-checking bench test_univ_shift_reg carries the monitor line (time, CLR, MODE, Q, Qn, CNT, DONE) in the same style as the flip-flop bench.

Test Plan:
Unless stated otherwise, WIDTH=4 and RESET_VAL=4'b1010; the clock toggles every 5 time units.
1. Reset: CLR=1 for 2 edges -> Q=1010, Qn=0101, CNT=0, DONE=0; release CLR with MODE=HOLD -> Q stays 1010.
2. Load/shift/DONE: LOAD D=0110, then 4 SHL edges with SIL=1 -> Q=1101,1011,0111,1111; CNT=1..4; DONE high only after the 4th edge; a 5th SHL -> CNT stays 4, DONE=0.
3. Right shifts: from Q=1001:
   - ASR -> 1100, then ASR -> 1110.
   - Reload 1001, SHR with SIR=0 -> 0100.
   - SO_R tracks Q[0] at every step.
4. Rotates: from Q=1000:
   - ROL x4 -> 0001,0010,0100,1000; DONE pulses on the 4th edge.
   - ROR x1 -> 0100; CNT stays 4.
5. Enable and clear: with EN=0 and MODE=SHL for 3 edges -> Q and CNT unchanged. Then MODE=CLEAR with EN=1 -> Q=0000 (not 1010), CNT=0.
6. Reset mid-operation: after 2 SHL ops (CNT=2), assert CLR while MODE=LOAD, D=1111 -> Q=1010, CNT=0; no DONE.
